axi2per_wr_resp_ctrl: RTL and testbench

//  Write-response sequencer for the axi2per bridge. Records ID/USER of every accepted AW in

---
 rtl/axi2per_wr_resp_ctrl_pkg.sv | 13 +
 rtl/axi2per_wr_resp_ctrl_if.sv | 34 +++
 rtl/axi2per_wr_resp_ctrl_id_fifo.sv | 66 ++++++
 rtl/axi2per_wr_resp_ctrl.sv | 98 +++++++++
 tb/tb_axi2per_wr_resp_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/axi2per_wr_resp_ctrl_pkg.sv
// Shared types and constants for the axi2per write-response controller.
package axi2per_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESP
    } wr_resp_state_e;

endpackage

// File: rtl/axi2per_wr_resp_ctrl_if.sv
// Handshake bundle between AW/W decode, the response controller and the B buffer.
// The slave modport is the controller side, the master modport is its environment.
interface axi2per_wr_resp_ctrl_if #(
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 6
);

    logic                  aw_valid;
    logic [ID_WIDTH-1:0]   aw_id;
    logic [USER_WIDTH-1:0] aw_user;
    logic                  aw_ready;

    logic                  beat_valid;
    logic                  beat_err;
    logic                  beat_last;
    logic                  beat_ready;

    logic                  b_valid;
    logic [1:0]            b_resp;
    logic [ID_WIDTH-1:0]   b_id;
    logic [USER_WIDTH-1:0] b_user;
    logic                  b_ready;

    modport slave (
        input  aw_valid, aw_id, aw_user, beat_valid, beat_err, beat_last, b_ready,
        output aw_ready, beat_ready, b_valid, b_resp, b_id, b_user
    );

    modport master (
        output aw_valid, aw_id, aw_user, beat_valid, beat_err, beat_last, b_ready,
        input  aw_ready, beat_ready, b_valid, b_resp, b_id, b_user
    );

endinterface

// File: rtl/axi2per_wr_resp_ctrl_id_fifo.sv
// Circular FIFO holding the {ID, USER} of every accepted AW until its B is sent.
// Push and pop may coincide even when full or empty; the count then stays put.
module axi2per_id_fifo #(
    parameter  int DATA_WIDTH = 10,
    parameter  int DEPTH      = 4,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_W-1:0]      count_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees the slot being written, so a full FIFO can still take a push alongside it.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & (~empty_o | push_i);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/axi2per_wr_resp_ctrl.sv
// Write-response sequencer: queues AW ID/USER, merges per-beat errors of each burst
// and emits one B response per burst, in AW order.
module axi2per_wr_resp_ctrl
    import axi2per_pkg::*;
#(
    parameter  int ID_WIDTH       = 4,
    parameter  int USER_WIDTH     = 6,
    parameter  int NB_OUTSTANDING = 4,
    localparam int CNT_W          = $clog2(NB_OUTSTANDING) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    axi2per_wr_resp_ctrl_if.slave  bus,
    output logic [CNT_W-1:0]       outstanding_o
);

    localparam int DATA_W = ID_WIDTH + USER_WIDTH;

    wr_resp_state_e    state_q, state_d;
    logic              err_acc_q, err_acc_d;
    logic              push, pop, full, empty;
    logic              beat_ready, b_valid;
    logic [DATA_W-1:0] head;

    assign push = bus.aw_valid & ~full;
    assign pop  = b_valid & bus.b_ready;

    axi2per_id_fifo #(
        .DATA_WIDTH (DATA_W),
        .DEPTH      (NB_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  ({bus.aw_id, bus.aw_user}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

    always_comb begin
        state_d    = state_q;
        err_acc_d  = err_acc_q;
        beat_ready = 1'b0;
        b_valid    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Beats of a burst are only taken once its AW sits at the queue head.
                beat_ready = ~empty;
                if (bus.beat_valid && !empty) begin
                    err_acc_d = err_acc_q | bus.beat_err;
                    state_d   = bus.beat_last ? RESP : ACCUM;
                end
            end
            ACCUM: begin
                beat_ready = 1'b1;
                if (bus.beat_valid) begin
                    err_acc_d = err_acc_q | bus.beat_err;
                    if (bus.beat_last) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                b_valid = 1'b1;
                if (bus.b_ready) begin
                    err_acc_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                err_acc_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            err_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_acc_q <= err_acc_d;
        end
    end

    // B fields are driven from registered state only and read zero outside RESP.
    assign bus.aw_ready   = ~full;
    assign bus.beat_ready = beat_ready;
    assign bus.b_valid    = b_valid;
    assign bus.b_resp     = (b_valid && err_acc_q) ? RESP_SLVERR : RESP_OKAY;
    assign bus.b_id       = b_valid ? head[DATA_W-1:USER_WIDTH] : '0;
    assign bus.b_user     = b_valid ? head[USER_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_axi2per_wr_resp_ctrl.sv
// Directed and random stimulus for axi2per_wr_resp_ctrl, checked cycle by cycle
// against a queue-based model of outstanding bursts.
module tb_axi2per_wr_resp_ctrl;

    localparam int NB = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] outstanding;

    always #5 clk = ~clk;

    axi2per_wr_resp_ctrl_if #(.ID_WIDTH(4), .USER_WIDTH(6)) bus ();

    axi2per_wr_resp_ctrl #(
        .ID_WIDTH       (4),
        .USER_WIDTH     (6),
        .NB_OUTSTANDING (NB)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus),
        .outstanding_o (outstanding)
    );

    typedef struct packed {
        logic [3:0] id;
        logic [5:0] user;
    } ent_t;

    // Model: bursts waiting for a B, plus whether the head burst has seen its last beat.
    ent_t q[$];
    bit   resp_pending;
    bit   burst_err;
    int   checks;
    int   failures;
    int   b_count;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("aw_ready", 32'(bus.aw_ready), 32'(q.size() < NB));
        checkVal("beat_ready", 32'(bus.beat_ready), 32'(!resp_pending && q.size() != 0));
        checkVal("b_valid", 32'(bus.b_valid), 32'(resp_pending));
        checkVal("b_resp", 32'(bus.b_resp), (resp_pending && burst_err) ? 32'd2 : 32'd0);
        checkVal("b_id", 32'(bus.b_id), resp_pending ? 32'(q[0].id) : 32'd0);
        checkVal("b_user", 32'(bus.b_user), resp_pending ? 32'(q[0].user) : 32'd0);
        checkVal("outstanding", 32'(outstanding), 32'(q.size()));
    endtask

    task automatic clearModel();
        q.delete();
        resp_pending = 1'b0;
        burst_err    = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model across the edge.
    task automatic applyStimulus(input logic awv, input logic [3:0] id, input logic [5:0] user,
                                 input logic bv, input logic be, input logic bl, input logic br);
        bit   aw_hs, beat_hs, b_hs;
        ent_t e;
        bus.aw_valid   = awv;
        bus.aw_id      = id;
        bus.aw_user    = user;
        bus.beat_valid = bv;
        bus.beat_err   = be;
        bus.beat_last  = bl;
        bus.b_ready    = br;
        checkOutput();
        aw_hs   = awv && (q.size() < NB);
        beat_hs = bv && !resp_pending && (q.size() != 0);
        b_hs    = resp_pending && br;
        @(posedge clk);
        #1;
        if (b_hs) begin
            void'(q.pop_front());
            resp_pending = 1'b0;
            burst_err    = 1'b0;
            b_count++;
        end
        if (beat_hs) begin
            burst_err = burst_err | be;
            if (bl) resp_pending = 1'b1;
        end
        if (aw_hs) begin
            e.id   = id;
            e.user = user;
            q.push_back(e);
        end
    endtask

    task automatic idleInputs();
        bus.aw_valid   = 1'b0;
        bus.aw_id      = '0;
        bus.aw_user    = '0;
        bus.beat_valid = 1'b0;
        bus.beat_err   = 1'b0;
        bus.beat_last  = 1'b0;
        bus.b_ready    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        b_count  = 0;
        clearModel();
        idleInputs();

        // Reset state
        #12;
        checkOutput();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single clean 4-beat burst, B one cycle after the last beat
        applyStimulus(1, 4'd3, 6'd5, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 1, 1);
        checkVal("t1_b_valid", 32'(bus.b_valid), 32'd1);
        checkVal("t1_b_id", 32'(bus.b_id), 32'd3);
        checkVal("t1_b_user", 32'(bus.b_user), 32'd5);
        checkVal("t1_b_resp", 32'(bus.b_resp), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkVal("t1_drained", 32'(outstanding), 32'd0);

        // 2: error on a middle beat, then a clean burst must report OKAY
        applyStimulus(1, 4'd1, 6'd11, 0, 0, 0, 1);
        applyStimulus(1, 4'd2, 6'd22, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 1, 1);
        checkVal("t2_resp_err", 32'(bus.b_resp), 32'd2);
        checkVal("t2_id_err", 32'(bus.b_id), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 1, 1);
        checkVal("t2_resp_clean", 32'(bus.b_resp), 32'd0);
        checkVal("t2_id_clean", 32'(bus.b_id), 32'd2);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // 3: fill the queue, hold a 5th AW, drain burst 0 so the slot reopens
        for (int i = 0; i < 4; i++) applyStimulus(1, 4'(i), 6'(i + 8), 0, 0, 0, 0);
        checkVal("t3_full_ready", 32'(bus.aw_ready), 32'd0);
        checkVal("t3_full_count", 32'(outstanding), 32'd4);
        applyStimulus(1, 4'd4, 6'd44, 1, 0, 0, 1);
        applyStimulus(1, 4'd4, 6'd44, 1, 0, 1, 1);
        checkVal("t3_head_id", 32'(bus.b_id), 32'd0);
        applyStimulus(1, 4'd4, 6'd44, 0, 0, 0, 1);
        for (int i = 0; i < 3 && q.size() < NB; i++) applyStimulus(1, 4'd4, 6'd44, 0, 0, 0, 0);
        checkVal("t3_refilled", 32'(outstanding), 32'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 1, 0);
            checkVal("t3_drain_id", 32'(bus.b_id), 32'(i + 1));
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
        end
        checkVal("t3_empty", 32'(outstanding), 32'd0);

        // 4: B buffer stalls for 5 cycles in RESP
        applyStimulus(1, 4'd7, 6'h2A, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            checkVal("t4_valid_hold", 32'(bus.b_valid), 32'd1);
            checkVal("t4_resp_hold", 32'(bus.b_resp), 32'd2);
            checkVal("t4_id_hold", 32'(bus.b_id), 32'd7);
            applyStimulus(0, 0, 0, 1, 0, 1, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkVal("t4_released", 32'(bus.b_valid), 32'd0);

        // 5: beats offered against an empty queue are back-pressured
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1, 1, 1);
        checkVal("t5_still_empty", 32'(outstanding), 32'd0);
        applyStimulus(1, 4'd9, 6'd3, 1, 0, 1, 1);
        checkVal("t5_beat_ready", 32'(bus.beat_ready), 32'd1);
        applyStimulus(0, 0, 0, 1, 0, 1, 1);
        checkVal("t5_b_clean", 32'(bus.b_resp), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // 6: reset mid-burst with two bursts queued
        applyStimulus(1, 4'hA, 6'd1, 0, 0, 0, 0);
        applyStimulus(1, 4'hB, 6'd2, 1, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        clearModel();
        checkOutput();
        idleInputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0, 1, 1);
        checkVal("t6_no_b", 32'(bus.b_valid), 32'd0);

        // Random traffic
        b_count = 0;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 3), 4'($urandom), 6'($urandom),
                          ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 2),
                          ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6));
        end
        checkVal("rand_progress", 32'(b_count > 10), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
